// File: rtl/shift_register_univ.sv
// Parametrised universal shift register: parallel load, barrel shift/rotate, and
// optional serial streaming with busy/done handshake (enabled by SHREG_STREAM_EN).
module shift_register_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_LOAD   = 3'b001,
    OP_SRL    = 3'b010,
    OP_SLL    = 3'b011,
    OP_SRA    = 3'b100,
    OP_ROR    = 3'b101,
    OP_ROL    = 3'b110,
    OP_STREAM = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] op_result;
  logic [31:0]      rot_amt;
  logic [2*WIDTH-1:0] ror_w, rol_w;

  assign op = op_e'(cmd_op);

  // Rotates go through a doubled copy so amount 0 and amounts >= WIDTH need no special case.
  always_comb begin
    rot_amt   = 32'(cmd_amt) % WIDTH;
    ror_w     = {q_q, q_q} >> rot_amt;
    rol_w     = {q_q, q_q} << rot_amt;
    op_result = q_q;
    unique case (op)
      OP_LOAD: op_result = cmd_data;
      OP_SRL:  op_result = q_q >> cmd_amt;
      OP_SLL:  op_result = q_q << cmd_amt;
      OP_SRA:  op_result = $signed(q_q) >>> cmd_amt;
      OP_ROR:  op_result = ror_w[WIDTH-1:0];
      OP_ROL:  op_result = rol_w[2*WIDTH-1:WIDTH];
      default: op_result = q_q;
    endcase
  end

  assign q = q_q;

`ifdef SHREG_STREAM_EN
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op == OP_STREAM) begin
            q_d     = cmd_data;
            cnt_d   = cmd_amt;
            state_d = SHIFT;
          end else begin
            q_d = op_result;
          end
        end
      end
      SHIFT: begin
        q_d   = {q_q[WIDTH-2:0], ser_in};
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign cmd_ready = !busy;
  assign ser_valid = busy;
  assign ser_out   = busy ? q_q[WIDTH-1] : 1'b0;
  assign done      = done_q;
`else
  logic unused_ser_in;

  assign unused_ser_in = ser_in;

  always_comb begin
    q_d = q_q;
    if (cmd_valid) q_d = op_result;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign busy      = 1'b0;
  assign cmd_ready = 1'b1;
  assign ser_valid = 1'b0;
  assign ser_out   = 1'b0;
  assign done      = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8); stream checks are built
// only when SHREG_STREAM_EN is defined, otherwise opcode 111 is checked as HOLD.
module tb_shift_register_univ;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  shift_register_univ #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .q         (q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge, then sample 1 time unit later.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] amt, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pattern;
  logic       saw_done;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_amt   = '0;
    cmd_data  = '0;
    ser_in    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_q",         64'(q),         64'h00);
    check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    check("rst_busy",      64'(busy),      64'h0);
    check("rst_done",      64'(done),      64'h0);
    check("rst_ser_valid", 64'(ser_valid), 64'h0);
    check("rst_ser_out",   64'(ser_out),   64'h0);

    // back-to-back arithmetic / rotate chain
    cmd_valid = 1'b1;
    cmd_op = 3'b001; cmd_amt = 3'd0; cmd_data = 8'h90; tick();
    check("load_90", 64'(q), 64'h90);
    cmd_op = 3'b100; cmd_amt = 3'd2; tick();
    check("sra_2", 64'(q), 64'hE4);
    cmd_op = 3'b101; cmd_amt = 3'd1; tick();
    check("ror_1", 64'(q), 64'h72);
    cmd_op = 3'b110; cmd_amt = 3'd4; tick();
    check("rol_4", 64'(q), 64'h27);
    cmd_op = 3'b011; cmd_amt = 3'd0; tick();
    check("sll_0", 64'(q), 64'h27);
    check("ready_chain", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b0;

    issue(3'b001, 3'd0, 8'h81);
    issue(3'b010, 3'd7, 8'h00);
    check("srl_7", 64'(q), 64'h01);
    issue(3'b001, 3'd0, 8'h81);
    issue(3'b011, 3'd3, 8'h00);
    check("sll_3", 64'(q), 64'h08);
    issue(3'b000, 3'd5, 8'hFF);
    check("hold", 64'(q), 64'h08);

    // no valid: no change
    cmd_op = 3'b001; cmd_data = 8'h55; tick();
    check("no_valid", 64'(q), 64'h08);

    issue(3'b001, 3'd0, 8'h80);
    issue(3'b100, 3'd7, 8'h00);
    check("sra_7", 64'(q), 64'hFF);
    issue(3'b001, 3'd0, 8'h01);
    issue(3'b110, 3'd7, 8'h00);
    check("rol_7", 64'(q), 64'h80);
    issue(3'b010, 3'd0, 8'h00);
    check("srl_0", 64'(q), 64'h80);

`ifdef SHREG_STREAM_EN
    // full stream with a LOAD held on cmd_valid throughout
    ser_in = 1'b1;
    issue(3'b111, 3'd7, 8'hA5);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_amt = 3'd0; cmd_data = 8'h3C;
    pattern = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stream_bit%0d", k), 64'(ser_out), 64'(pattern[7-k]));
      check("stream_valid", 64'(ser_valid), 64'h1);
      check("stream_ready", 64'(cmd_ready), 64'h0);
      check("stream_done_lo", 64'(done), 64'h0);
      tick();
    end
    check("stream_q",         64'(q),         64'hFF);
    check("stream_done",      64'(done),      64'h1);
    check("stream_ready_end", 64'(cmd_ready), 64'h1);
    check("stream_busy_end",  64'(busy),      64'h0);
    tick();
    cmd_valid = 1'b0;
    check("held_load", 64'(q), 64'h3C);
    check("done_pulse", 64'(done), 64'h0);

    // short stream
    ser_in = 1'b0;
    issue(3'b111, 3'd1, 8'hC0);
    check("short_bit0", 64'(ser_out), 64'h1);
    tick();
    check("short_bit1", 64'(ser_out), 64'h1);
    check("short_done_lo", 64'(done), 64'h0);
    tick();
    check("short_done", 64'(done), 64'h1);
    check("short_q", 64'(q), 64'h00);
    check("short_sv", 64'(ser_valid), 64'h0);

    // reset mid-stream
    issue(3'b111, 3'd7, 8'hA5);
    tick();
    tick();
    tick();
    check("mid_busy_pre", 64'(busy), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_q",     64'(q),         64'h00);
    check("mid_rst_busy",  64'(busy),      64'h0);
    check("mid_rst_sv",    64'(ser_valid), 64'h0);
    check("mid_rst_so",    64'(ser_out),   64'h0);
    check("mid_rst_ready", 64'(cmd_ready), 64'h1);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("mid_rst_no_done", 64'(saw_done), 64'h0);
`else
    issue(3'b001, 3'd0, 8'hA5);
    issue(3'b111, 3'd7, 8'h3C);
    check("op7_hold",  64'(q),         64'hA5);
    check("op7_busy",  64'(busy),      64'h0);
    check("op7_ready", 64'(cmd_ready), 64'h1);
    check("op7_sv",    64'(ser_valid), 64'h0);
    tick();
    check("op7_done",  64'(done),      64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
